ipm2t_hssthp_rst_hpll_multi_v1_4: RTL and testbench
===================================================

# ipm2t_hssthp_rst_hpll_multi_v1_4

Parametrised HPLL reset/power-up sequencer for up to four HPLLs in one HSSTHP quad group. It supersedes the fixed two-PLL controller with a per-PLL participation mask, programmable phase durations, a lock-acquisition timeout, bounded automatic retry and a sticky failure state. It sits between the free-running clock domain and the HPLL hard-macro control pins, and gates lane-level reset sequencing through `o_hpll_done` and `o_tx_sync`.

## Interface
- `NUM_HPLL`, 2, number of HPLLs controlled (1..4).
- `LOCK_MASK`, 4'b0011, bit i=1: HPLL i participates; bits ≥ NUM_HPLL ignored.
- `PD_CYC`, 4000, cycles in powerdown phase (≥2).
- `RST_CYC`, 100, cycles in reset phase (≥2).
- `LOCK_DEB_CYC`, 2048, consecutive locked cycles required (≥2).
- `LOCK_TIMEOUT_CYC`, 65535, max cycles in calibration phase (> LOCK_DEB_CYC).
- `SYNC_CYC`, 16, width of each sync pulse (≥1).
- `MAX_RETRY`, 3, automatic retries before failure (0..15).
- `clk` in 1 free-running clock.
- `rst_n` in 1 asynchronous active-low reset.
- `i_hpll_rst` in 1 synchronous soft restart, level, active-high.
- `i_hpll_ready` in NUM_HPLL raw HPLL lock, asynchronous.
- `P_HPLL_POWERDOWN` out NUM_HPLL per-PLL powerdown.
- `P_HPLL_RST` out NUM_HPLL per-PLL reset.
- `P_HPLL_VCO_CALIB_EN` out NUM_HPLL per-PLL VCO calibration enable.
- `P_REFCLK_DIV_SYNC` out NUM_HPLL refclk divider sync.
- `P_HPLL_DIV_SYNC` out NUM_HPLL HPLL divider sync.
- `o_tx_sync` out 1 TX sync pulse toward lane resets.
- `o_hpll_done` out 1 all participating HPLLs up.
- `o_fail` out 1 sticky failure.
- `o_retry_cnt` out 4 retries consumed.
- `o_state` out 3 current FSM state (debug).

## Operation
- `i_hpll_ready` passes through a 2-flop synchronizer per bit. `lock` = AND of synced bits where LOCK_MASK=1. An all-zero effective mask gives lock=1.
- States (`o_state` encoding): PD=0, RST=1, CAL=2, DIVSYNC=3, TXSYNC=4, DONE=5, FAIL=7.
- The phase counter clears on every state entry. A timed state exits when the counter reaches N-1, so it lasts exactly N cycles.
- PD: POWERDOWN=1, RST=1. After PD_CYC cycles → RST.
- RST: POWERDOWN=0, RST=1. After RST_CYC cycles → CAL.
- CAL: RST=0, VCO_CALIB_EN=1.
  - The debounce counter increments while lock=1 and clears to 0 when lock=0.
  - Reaching LOCK_DEB_CYC-1 with lock=1 → DIVSYNC.
  - Phase counter reaching LOCK_TIMEOUT_CYC-1 → retry.
  - If both conditions hit in the same cycle, the debounce exit wins.
- DIVSYNC: REFCLK_DIV_SYNC=1 and HPLL_DIV_SYNC=1 for SYNC_CYC cycles → TXSYNC.
- TXSYNC: o_tx_sync=1 for SYNC_CYC cycles → DONE.
- DONE: o_hpll_done=1. Stays until lock=0.
- Retry: lock=0 in DIVSYNC, TXSYNC or DONE, or a CAL timeout.
  - If o_retry_cnt < MAX_RETRY: o_retry_cnt+1 and → PD.
  - Otherwise → FAIL with o_retry_cnt unchanged.
- FAIL: o_fail=1, all PLLs held in POWERDOWN=1 and RST=1. Exited only by i_hpll_rst.
- i_hpll_rst=1 overrides every other transition: → PD, clears o_retry_cnt, o_fail and all counters. The FSM is held in PD while the level stays high; the PD count starts on the first cycle after it falls.
- Non-participating PLL bits (mask=0, or index ≥ NUM_HPLL): POWERDOWN=1, RST=1, all other per-PLL outputs 0, at all times.
- o_retry_cnt saturates at 15.

## Timing
- Reset values (rst_n=0, asynchronous):
  - state=PD, POWERDOWN=all 1, RST=all 1.
  - VCO_CALIB_EN, DIV syncs, o_tx_sync, o_hpll_done, o_fail, o_retry_cnt: all 0.
  - Synchronizer and debounce registers: 0.
- All outputs are registered and change on the same clk edge as `o_state`. There is no combinational path from any input to any output.
- Input-to-lock latency is 2 cycles. Loss of lock in DONE drops o_hpll_done 3 edges after i_hpll_ready falls: 2 synchronizer cycles plus the state register.
- Nominal lock-up time from rst_n release with ready already high: PD_CYC + RST_CYC + LOCK_DEB_CYC + 2·SYNC_CYC cycles.
- rst_n assertion mid-sequence returns every output to its reset value immediately, without waiting for a clock edge.

## Test plan
Bench parameters: NUM_HPLL=2, LOCK_MASK=2'b11, PD_CYC=8, RST_CYC=4, LOCK_DEB_CYC=16, LOCK_TIMEOUT_CYC=100, SYNC_CYC=4, MAX_RETRY=2.
- Nominal bring-up: ready=2'b11 held from reset release → o_hpll_done rises exactly 36 cycles after the first active edge. o_tx_sync is high for cycles 32..35 and the DIV syncs for 28..31.
- Debounce restart: in CAL, drop ready[0] for 1 cycle after 10 locked cycles → DIVSYNC entry delayed so that 16 full consecutive locked cycles follow the glitch. o_retry_cnt stays 0.
- Timeout/fail: ready=2'b00 throughout → two retries (o_retry_cnt=1, then 2), then FAIL entered 336 cycles after reset. o_fail=1, and POWERDOWN=2'b11 and RST=2'b11 thereafter.
- Loss of lock: in DONE, drop ready[1] → o_hpll_done falls 3 edges later, state=PD, o_retry_cnt=1. The re-lock completes 36 cycles after PD entry.
- Masking: LOCK_MASK=2'b01, ready=2'b01 → done at 36 cycles. Throughout, P_HPLL_POWERDOWN[1]=1, P_HPLL_RST[1]=1 and VCO_CALIB_EN[1]=0.
- Recovery and reset:
  - In FAIL, pulse i_hpll_rst for 3 cycles → o_fail=0, o_retry_cnt=0, state PD.
  - Assert rst_n=0 mid-DIVSYNC → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/ipm2t_hssthp_rst_hpll_multi_v1_4.sv
`default_nettype none
// ============================================================================
// Module   : ipm2t_hssthp_rst_hpll_multi_v1_4
// Brief    : Reset / power-up sequencer for up to four HPLLs of one HSSTHP
//            quad group. Walks powerdown, reset, VCO calibration with lock
//            debounce and timeout, divider sync and TX sync phases. Retries
//            automatically a bounded number of times, then parks in a sticky
//            failure state until a soft restart.
// Revision : 1.4 - per-PLL mask, programmable phases, timeout and retry
// ============================================================================
module ipm2t_hssthp_rst_hpll_multi_v1_4 #(
  parameter int         NUM_HPLL         = 2,
  parameter logic [3:0] LOCK_MASK        = 4'b0011,
  parameter int         PD_CYC           = 4000,
  parameter int         RST_CYC          = 100,
  parameter int         LOCK_DEB_CYC     = 2048,
  parameter int         LOCK_TIMEOUT_CYC = 65535,
  parameter int         SYNC_CYC         = 16,
  parameter int         MAX_RETRY        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_hpll_rst,
  input  logic [NUM_HPLL-1:0] i_hpll_ready,
  output logic [NUM_HPLL-1:0] P_HPLL_POWERDOWN,
  output logic [NUM_HPLL-1:0] P_HPLL_RST,
  output logic [NUM_HPLL-1:0] P_HPLL_VCO_CALIB_EN,
  output logic [NUM_HPLL-1:0] P_REFCLK_DIV_SYNC,
  output logic [NUM_HPLL-1:0] P_HPLL_DIV_SYNC,
  output logic                o_tx_sync,
  output logic                o_hpll_done,
  output logic                o_fail,
  output logic [3:0]          o_retry_cnt,
  output logic [2:0]          o_state
);

  // Phase counter must hold the longest timed phase minus one.
  localparam int c_MAX_A   = (PD_CYC > RST_CYC) ? PD_CYC : RST_CYC;
  localparam int c_MAX_B   = (LOCK_TIMEOUT_CYC > SYNC_CYC) ? LOCK_TIMEOUT_CYC : SYNC_CYC;
  localparam int c_MAX_CYC = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CW      = $clog2(c_MAX_CYC);
  localparam int c_DW      = $clog2(LOCK_DEB_CYC);

  localparam logic [c_CW-1:0] c_PD_LAST   = c_CW'(PD_CYC - 1);
  localparam logic [c_CW-1:0] c_RST_LAST  = c_CW'(RST_CYC - 1);
  localparam logic [c_CW-1:0] c_TO_LAST   = c_CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [c_CW-1:0] c_SYNC_LAST = c_CW'(SYNC_CYC - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(LOCK_DEB_CYC - 1);
  localparam logic [c_DW-1:0] c_DEB_ONE   = c_DW'(1);
  localparam logic [3:0]      c_MAX_RETRY = 4'(MAX_RETRY);

  // Participating PLLs; bits at or above NUM_HPLL simply fall off.
  localparam logic [NUM_HPLL-1:0] c_PART = LOCK_MASK[NUM_HPLL-1:0];

  typedef enum logic [2:0] {
    ST_PD      = 3'd0,
    ST_RST     = 3'd1,
    ST_CAL     = 3'd2,
    ST_DIVSYNC = 3'd3,
    ST_TXSYNC  = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAIL    = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [c_CW-1:0]     cnt_q, cnt_d;
  logic [c_DW-1:0]     deb_q, deb_d;
  logic [3:0]          retry_q, retry_d;
  logic [NUM_HPLL-1:0] sync1_q, sync2_q;
  logic                lock;
  logic                take_retry;

  logic [NUM_HPLL-1:0] pd_q, pd_d;
  logic [NUM_HPLL-1:0] prst_q, prst_d;
  logic [NUM_HPLL-1:0] cal_q, cal_d;
  logic [NUM_HPLL-1:0] div_q, div_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;

  // Two-flop synchronizer for the asynchronous raw lock indications.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_hpll_ready;
      sync2_q <= sync1_q;
    end
  end

  // Non-participating bits are forced true so an empty mask reads as locked.
  assign lock = &(sync2_q | ~c_PART);

  // Next-state, phase counter, debounce counter and retry bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + c_CNT_ONE;
    deb_d      = '0;
    retry_d    = retry_q;
    take_retry = 1'b0;
    if (i_hpll_rst) begin
      state_d = ST_PD;
      cnt_d   = '0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        ST_PD:  if (cnt_q == c_PD_LAST)  state_d = ST_RST;
        ST_RST: if (cnt_q == c_RST_LAST) state_d = ST_CAL;
        ST_CAL: begin
          if (lock) deb_d = deb_q + c_DEB_ONE;
          // A completed debounce wins over a simultaneous timeout.
          if (lock && deb_q == c_DEB_LAST) state_d = ST_DIVSYNC;
          else if (cnt_q == c_TO_LAST)     take_retry = 1'b1;
        end
        ST_DIVSYNC: begin
          if (!lock)                       take_retry = 1'b1;
          else if (cnt_q == c_SYNC_LAST)   state_d = ST_TXSYNC;
        end
        ST_TXSYNC: begin
          if (!lock)                       take_retry = 1'b1;
          else if (cnt_q == c_SYNC_LAST)   state_d = ST_DONE;
        end
        ST_DONE: begin
          cnt_d = cnt_q;
          if (!lock) take_retry = 1'b1;
        end
        ST_FAIL: cnt_d = cnt_q;
        default: state_d = ST_PD;
      endcase
      if (take_retry) begin
        if (retry_q < c_MAX_RETRY) begin
          state_d = ST_PD;
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
        end else begin
          state_d = ST_FAIL;
        end
      end
      if (state_d != state_q) begin
        cnt_d = '0;
        deb_d = '0;
      end
    end
  end

  // Per-PLL and status outputs decoded from the next state so they register
  // on the same edge as the state itself.
  always_comb begin
    pd_d   = ~c_PART;
    prst_d = ~c_PART;
    cal_d  = '0;
    div_d  = '0;
    tx_d   = 1'b0;
    done_d = 1'b0;
    fail_d = 1'b0;
    if (state_d inside {ST_PD, ST_FAIL})         pd_d   = '1;
    if (state_d inside {ST_PD, ST_RST, ST_FAIL}) prst_d = '1;
    if (state_d == ST_CAL)     cal_d  = c_PART;
    if (state_d == ST_DIVSYNC) div_d  = c_PART;
    if (state_d == ST_TXSYNC)  tx_d   = 1'b1;
    if (state_d == ST_DONE)    done_d = 1'b1;
    if (state_d == ST_FAIL)    fail_d = 1'b1;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PD;
      cnt_q   <= '0;
      deb_q   <= '0;
      retry_q <= 4'd0;
      pd_q    <= '1;
      prst_q  <= '1;
      cal_q   <= '0;
      div_q   <= '0;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      retry_q <= retry_d;
      pd_q    <= pd_d;
      prst_q  <= prst_d;
      cal_q   <= cal_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign P_HPLL_POWERDOWN    = pd_q;
  assign P_HPLL_RST          = prst_q;
  assign P_HPLL_VCO_CALIB_EN = cal_q;
  assign P_REFCLK_DIV_SYNC   = div_q;
  assign P_HPLL_DIV_SYNC     = div_q;
  assign o_tx_sync           = tx_q;
  assign o_hpll_done         = done_q;
  assign o_fail              = fail_q;
  assign o_retry_cnt         = retry_q;
  assign o_state             = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ipm2t_hssthp_rst_hpll_multi_v1_4.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ipm2t_hssthp_rst_hpll_multi_v1_4
// Brief    : Self-checking bench for the HPLL sequencer: a timestamp-based
//            reference model plus directed timing checks.
// Revision : 1.4
// ============================================================================
module tb_ipm2t_hssthp_rst_hpll_multi_v1_4;

  localparam int         PD_CYC   = 8;
  localparam int         RST_CYC  = 4;
  localparam int         DEB_CYC  = 16;
  localparam int         TO_CYC   = 100;
  localparam int         SYNC_CYC = 4;
  localparam int         MAX_RTY  = 2;
  localparam logic [1:0] MASK     = 2'b11;

  // Debug state codes as published for o_state.
  localparam int M_PD = 0, M_RST = 1, M_CAL = 2, M_DIV = 3, M_TX = 4, M_DONE = 5, M_FAIL = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, hrst;
  logic [1:0] rdy, rdy_m;
  logic [1:0] pd, rs, cal, rdiv, hdiv;
  logic       txs, done, fail;
  logic [3:0] rcnt;
  logic [2:0] st;
  logic [1:0] pd_m, rs_m, cal_m, rdiv_m, hdiv_m;
  logic       txs_m, done_m, fail_m;
  logic [3:0] rcnt_m;
  logic [2:0] st_m;

  ipm2t_hssthp_rst_hpll_multi_v1_4 #(
    .NUM_HPLL(2), .LOCK_MASK(4'b0011), .PD_CYC(PD_CYC), .RST_CYC(RST_CYC),
    .LOCK_DEB_CYC(DEB_CYC), .LOCK_TIMEOUT_CYC(TO_CYC), .SYNC_CYC(SYNC_CYC), .MAX_RETRY(MAX_RTY)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_hpll_rst(hrst), .i_hpll_ready(rdy),
    .P_HPLL_POWERDOWN(pd), .P_HPLL_RST(rs), .P_HPLL_VCO_CALIB_EN(cal),
    .P_REFCLK_DIV_SYNC(rdiv), .P_HPLL_DIV_SYNC(hdiv), .o_tx_sync(txs),
    .o_hpll_done(done), .o_fail(fail), .o_retry_cnt(rcnt), .o_state(st)
  );

  ipm2t_hssthp_rst_hpll_multi_v1_4 #(
    .NUM_HPLL(2), .LOCK_MASK(4'b0001), .PD_CYC(PD_CYC), .RST_CYC(RST_CYC),
    .LOCK_DEB_CYC(DEB_CYC), .LOCK_TIMEOUT_CYC(TO_CYC), .SYNC_CYC(SYNC_CYC), .MAX_RETRY(MAX_RTY)
  ) u_dut_m (
    .clk(clk), .rst_n(rst_n), .i_hpll_rst(hrst), .i_hpll_ready(rdy_m),
    .P_HPLL_POWERDOWN(pd_m), .P_HPLL_RST(rs_m), .P_HPLL_VCO_CALIB_EN(cal_m),
    .P_REFCLK_DIV_SYNC(rdiv_m), .P_HPLL_DIV_SYNC(hdiv_m), .o_tx_sync(txs_m),
    .o_hpll_done(done_m), .o_fail(fail_m), .o_retry_cnt(rcnt_m), .o_state(st_m)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: edge count since reset release, state with its entry
  // edge, length of the current locked run in calibration, retries used,
  // and the history of ready values presented at each edge.
  int         m_n, m_st, m_entry, m_run, m_retry;
  logic [1:0] m_hist[$];
  bit         m_mchk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_st = M_PD; m_entry = 0; m_run = 0; m_retry = 0;
    m_hist.delete();
  endtask

  task automatic model_edge(input logic [1:0] r, input logic h);
    logic [1:0] seen;
    logic       lk, rty;
    int         held, nxt;
    m_n++;
    // Two synchronizer stages: the lock seen at edge n is the ready of edge n-2.
    seen = (m_n >= 3) ? m_hist[m_n-3] : 2'b00;
    m_hist.push_back(r);
    lk   = ((seen & MASK) == MASK);
    held = m_n - m_entry;
    nxt  = m_st;
    rty  = 1'b0;
    if (h) begin
      nxt = M_PD; m_retry = 0;
    end else begin
      case (m_st)
        M_PD:   if (held == PD_CYC)  nxt = M_RST;
        M_RST:  if (held == RST_CYC) nxt = M_CAL;
        M_CAL: begin
          m_run = lk ? m_run + 1 : 0;
          if (m_run == DEB_CYC) nxt = M_DIV;
          else if (held == TO_CYC) rty = 1'b1;
        end
        M_DIV:  if (!lk) rty = 1'b1; else if (held == SYNC_CYC) nxt = M_TX;
        M_TX:   if (!lk) rty = 1'b1; else if (held == SYNC_CYC) nxt = M_DONE;
        M_DONE: if (!lk) rty = 1'b1;
        default: ;
      endcase
      if (rty) begin
        if (m_retry < MAX_RTY) begin
          nxt = M_PD; m_retry = (m_retry < 15) ? m_retry + 1 : 15;
        end else nxt = M_FAIL;
      end
    end
    if (h || nxt != m_st) begin
      m_st = nxt; m_entry = m_n; m_run = 0;
    end
  endtask

  task automatic check_model();
    logic [1:0] e_pd, e_rs, e_cal, e_div;
    e_pd  = (m_st == M_PD || m_st == M_FAIL) ? 2'b11 : ~MASK;
    e_rs  = (m_st == M_PD || m_st == M_RST || m_st == M_FAIL) ? 2'b11 : ~MASK;
    e_cal = (m_st == M_CAL) ? MASK : 2'b00;
    e_div = (m_st == M_DIV) ? MASK : 2'b00;
    chk("state", 32'(st), 32'(m_st));
    chk("powerdown", 32'(pd), 32'(e_pd));
    chk("pll_rst", 32'(rs), 32'(e_rs));
    chk("vco_cal", 32'(cal), 32'(e_cal));
    chk("refclk_div_sync", 32'(rdiv), 32'(e_div));
    chk("hpll_div_sync", 32'(hdiv), 32'(e_div));
    chk("tx_sync", 32'(txs), 32'(m_st == M_TX));
    chk("done", 32'(done), 32'(m_st == M_DONE));
    chk("fail", 32'(fail), 32'(m_st == M_FAIL));
    chk("retry_cnt", 32'(rcnt), 32'(m_retry));
  endtask

  // The masked instance only has PLL 0 participating and sees ready=01.
  task automatic check_masked();
    chk("mask_pd1", 32'(pd_m[1]), 32'd1);
    chk("mask_rst1", 32'(rs_m[1]), 32'd1);
    chk("mask_cal1", 32'(cal_m[1]), 32'd0);
    chk("mask_div1", 32'({rdiv_m[1], hdiv_m[1]}), 32'd0);
    chk("mask_done", 32'(done_m), 32'(m_n >= 36));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(st), 32'(M_PD));
    chk({tag, "_pd"}, 32'(pd), 32'h3);
    chk({tag, "_rst"}, 32'(rs), 32'h3);
    chk({tag, "_cal"}, 32'(cal), 32'h0);
    chk({tag, "_div"}, 32'({rdiv, hdiv}), 32'h0);
    chk({tag, "_misc"}, 32'({txs, done, fail, rcnt}), 32'h0);
  endtask

  task automatic step();
    model_edge(rdy, hrst);
    @(posedge clk);
    @(negedge clk);
    check_model();
    if (m_mchk) check_masked();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra, dur, k, g, h, pd_entry, lsel;
    rst_n = 1'b0; hrst = 1'b0; rdy = 2'b11; rdy_m = 2'b01;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("por");
    chk("por_mask_pd", 32'(pd_m), 32'h3);
    rst_n = 1'b1;

    // Nominal bring-up, masked instance in parallel.
    m_mchk = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("nom_done", 32'(done), 32'(m_n >= 36));
      chk("nom_tx", 32'(txs), 32'(m_n >= 32 && m_n <= 35));
      chk("nom_div", 32'(rdiv), (m_n >= 28 && m_n <= 31) ? 32'h3 : 32'h0);
    end
    m_mchk = 1'b0;

    // Loss of lock in DONE: ready[1] drops for 1..3 cycles.
    extra = $urandom_range(0, 5);
    repeat (extra) step();
    dur = $urandom_range(1, 3);
    rdy = 2'b01;
    step();
    chk("lol_done_e1", 32'(done), 32'd1);
    if (dur == 1) rdy = 2'b11;
    step();
    chk("lol_done_e2", 32'(done), 32'd1);
    if (dur <= 2) rdy = 2'b11;
    step();
    chk("lol_done_e3", 32'(done), 32'd0);
    chk("lol_state", 32'(st), 32'(M_PD));
    chk("lol_retry", 32'(rcnt), 32'd1);
    rdy = 2'b11;
    pd_entry = m_n;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("relock_done", 32'(done), 32'(m_n - pd_entry >= 36));
    end

    // Debounce restart after L locked calibration cycles.
    hrst = 1'b1;
    step();
    chk("srst_retry", 32'(rcnt), 32'd0);
    hrst = 1'b0;
    h = m_n;
    lsel = $urandom_range(5, 14);
    k = h + lsel + 11;
    g = k + 2;
    while (m_n < k - 1) step();
    rdy = 2'b10;
    step();
    rdy = 2'b11;
    while (m_n < g + 16) begin
      step();
      if (m_n >= g) chk("deb_divsync_entry", 32'(st == 3'd3), 32'(m_n == g + 16));
    end
    repeat (12) step();
    chk("deb_done", 32'(done), 32'd1);
    chk("deb_retry", 32'(rcnt), 32'd0);

    // Timeout / fail with no lock from reset.
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset("rst2");
    @(negedge clk);
    model_reset();
    rdy = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 340; i++) begin
      step();
      if (m_n == 112) chk("to_retry1", 32'({st, rcnt}), 32'({3'd0, 4'd1}));
      if (m_n == 224) chk("to_retry2", 32'({st, rcnt}), 32'({3'd0, 4'd2}));
      if (m_n == 335) chk("to_not_fail_yet", 32'(fail), 32'd0);
      if (m_n == 336) chk("to_fail_entry", 32'({st, fail}), 32'({3'd7, 1'b1}));
    end
    for (int i = 0; i < 10; i++) begin
      rdy = 2'($urandom_range(0, 3));
      step();
      chk("fail_hold", 32'({fail, pd, rs}), 32'({1'b1, 2'b11, 2'b11}));
    end

    // Recovery with a 3-cycle soft restart, then rst_n mid-DIVSYNC.
    hrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rec_clear", 32'({fail, rcnt, st}), 32'h0);
    end
    hrst = 1'b0;
    rdy = 2'b11;
    for (int i = 0; i < 60; i++) begin
      step();
      if (m_st == M_DIV) break;
    end
    chk("rec_reached_div", 32'(st), 32'(M_DIV));
    extra = $urandom_range(0, 2);
    repeat (extra) step();
    chk("rec_div_active", 32'(rdiv), 32'h3);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Randomized lock glitches, long outages and occasional soft restarts.
    for (int i = 0; i < 700; i++) begin
      if (i >= 300 && i < 450) rdy = 2'b00;
      else rdy = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      hrst = ($urandom_range(0, 99) == 0);
      step();
    end
    hrst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
